// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter for the W stage: shares the single write port between
// the in-order pipeline and the variable-latency mult/div unit, with result buffering and starvation relief.
module wb_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter logic [4:0]  STATUS_REG   = 5'd30,
  parameter logic [31:0] MUL_EXC_CODE = 32'd4,
  parameter logic [31:0] DIV_EXC_CODE = 32'd5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pipe_wb_valid,
  input  logic [4:0]  pipe_wb_rd,
  input  logic [31:0] pipe_wb_data,
  input  logic        md_start,
  input  logic [4:0]  md_start_rd,
  input  logic        md_start_is_div,
  input  logic        md_resultRDY,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic [4:0]  src_a_rd,
  input  logic [4:0]  src_b_rd,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data,
  output logic        md_issue_stall,
  output logic        raw_hazard,
  output logic        pipe_hold
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_PEND
  } state_e;

  state_e             state_q, state_d;
  logic [4:0]         cap_rd_q, cap_rd_d;
  logic               cap_div_q, cap_div_d;
  logic [4:0]         buf_rd_q, buf_rd_d;
  logic [31:0]        buf_data_q, buf_data_d;
  logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic               pipe_hold_q, pipe_hold_d;

  logic               pipe_req;
  logic               md_done;
  logic               md_tgt_we;
  logic [4:0]         md_tgt_rd;
  logic [31:0]        md_tgt_data;

  function automatic logic src_hits(input logic [4:0] src, input logic [4:0] t0,
                                    input logic [4:0] t1);
    return (src != '0) && ((src == t0) || (src == t1));
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cap_rd_q     <= '0;
      cap_div_q    <= 1'b0;
      buf_rd_q     <= '0;
      buf_data_q   <= '0;
      starve_cnt_q <= '0;
      pipe_hold_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cap_rd_q     <= cap_rd_d;
      cap_div_q    <= cap_div_d;
      buf_rd_q     <= buf_rd_d;
      buf_data_q   <= buf_data_d;
      starve_cnt_q <= starve_cnt_d;
      pipe_hold_q  <= pipe_hold_d;
    end
  end

  // Where a finished mult/div op lands: exceptions are redirected to the status register.
  always_comb begin
    if (md_exception) begin
      md_tgt_we   = 1'b1;
      md_tgt_rd   = STATUS_REG;
      md_tgt_data = cap_div_q ? DIV_EXC_CODE : MUL_EXC_CODE;
    end else begin
      md_tgt_we   = (cap_rd_q != '0);
      md_tgt_rd   = cap_rd_q;
      md_tgt_data = md_result;
    end
  end

  assign pipe_req = pipe_wb_valid && (pipe_wb_rd != '0) && !pipe_hold_q;
  assign md_done  = (state_q == S_BUSY) && md_resultRDY;

  always_comb begin
    state_d      = state_q;
    cap_rd_d     = cap_rd_q;
    cap_div_d    = cap_div_q;
    buf_rd_d     = buf_rd_q;
    buf_data_d   = buf_data_q;
    starve_cnt_d = '0;
    pipe_hold_d  = 1'b0;
    rf_we        = 1'b0;
    rf_rd        = '0;
    rf_data      = '0;

    unique case (state_q)
      S_IDLE: begin
        if (pipe_req) begin
          rf_we   = 1'b1;
          rf_rd   = pipe_wb_rd;
          rf_data = pipe_wb_data;
        end
        if (md_start) begin
          state_d   = S_BUSY;
          cap_rd_d  = md_start_rd;
          cap_div_d = md_start_is_div;
        end
      end
      S_BUSY: begin
        if (pipe_req) begin
          rf_we   = 1'b1;
          rf_rd   = pipe_wb_rd;
          rf_data = pipe_wb_data;
          if (md_done) begin
            if (md_tgt_we) begin
              state_d    = S_PEND;
              buf_rd_d   = md_tgt_rd;
              buf_data_d = md_tgt_data;
            end else begin
              state_d = S_IDLE;
            end
          end
        end else if (md_done) begin
          state_d = S_IDLE;
          if (md_tgt_we) begin
            rf_we   = 1'b1;
            rf_rd   = md_tgt_rd;
            rf_data = md_tgt_data;
          end
        end
      end
      S_PEND: begin
        // pipe_req is already masked while pipe_hold is high, so the buffer wins that cycle.
        if (pipe_req) begin
          rf_we        = 1'b1;
          rf_rd        = pipe_wb_rd;
          rf_data      = pipe_wb_data;
          starve_cnt_d = starve_cnt_q + CNT_W'(1);
          pipe_hold_d  = (starve_cnt_d == CNT_W'(STARVE_LIMIT));
        end else begin
          rf_we   = 1'b1;
          rf_rd   = buf_rd_q;
          rf_data = buf_data_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    raw_hazard = 1'b0;
    if (state_q == S_BUSY) begin
      raw_hazard = src_hits(src_a_rd, cap_rd_q, STATUS_REG) ||
                   src_hits(src_b_rd, cap_rd_q, STATUS_REG);
    end else if (state_q == S_PEND) begin
      raw_hazard = src_hits(src_a_rd, buf_rd_q, buf_rd_q) ||
                   src_hits(src_b_rd, buf_rd_q, buf_rd_q);
    end
  end

  assign md_issue_stall = (state_q != S_IDLE);
  assign pipe_hold      = pipe_hold_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: cycle vectors with expected outputs are queued
// as they are driven and compared just before the next clock edge.
module tb_wb_port_arbiter;

  logic        clock;
  logic        reset;
  logic        pipe_wb_valid;
  logic [4:0]  pipe_wb_rd;
  logic [31:0] pipe_wb_data;
  logic        md_start;
  logic [4:0]  md_start_rd;
  logic        md_start_is_div;
  logic        md_resultRDY;
  logic [31:0] md_result;
  logic        md_exception;
  logic [4:0]  src_a_rd;
  logic [4:0]  src_b_rd;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic        md_issue_stall;
  logic        raw_hazard;
  logic        pipe_hold;

  wb_port_arbiter #(
    .STARVE_LIMIT(4),
    .STATUS_REG(5'd30),
    .MUL_EXC_CODE(32'd4),
    .DIV_EXC_CODE(32'd5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .pipe_wb_valid(pipe_wb_valid),
    .pipe_wb_rd(pipe_wb_rd),
    .pipe_wb_data(pipe_wb_data),
    .md_start(md_start),
    .md_start_rd(md_start_rd),
    .md_start_is_div(md_start_is_div),
    .md_resultRDY(md_resultRDY),
    .md_result(md_result),
    .md_exception(md_exception),
    .src_a_rd(src_a_rd),
    .src_b_rd(src_b_rd),
    .rf_we(rf_we),
    .rf_rd(rf_rd),
    .rf_data(rf_data),
    .md_issue_stall(md_issue_stall),
    .raw_hazard(raw_hazard),
    .pipe_hold(pipe_hold)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    string       tag;
    logic        rst;
    logic        pv;
    logic [4:0]  prd;
    logic [31:0] pdata;
    logic        ms;
    logic [4:0]  mrd;
    logic        mdiv;
    logic        rdy;
    logic [31:0] res;
    logic        exc;
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic        e_stall;
    logic        e_haz;
    logic        e_hold;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input string tag, input int rst, input int pv, input int prd,
                              input int pdata, input int ms, input int mrd, input int mdiv,
                              input int rdy, input int res, input int exc, input int sa,
                              input int sb, input int we, input int rd, input int data,
                              input int stall, input int haz, input int hold);
    vec_t v;
    v.tag = tag;         v.rst = 1'(rst);     v.pv = 1'(pv);
    v.prd = 5'(prd);     v.pdata = 32'(pdata);
    v.ms = 1'(ms);       v.mrd = 5'(mrd);     v.mdiv = 1'(mdiv);
    v.rdy = 1'(rdy);     v.res = 32'(res);    v.exc = 1'(exc);
    v.sa = 5'(sa);       v.sb = 5'(sb);
    v.e_we = 1'(we);     v.e_rd = 5'(rd);     v.e_data = 32'(data);
    v.e_stall = 1'(stall); v.e_haz = 1'(haz); v.e_hold = 1'(hold);
    return v;
  endfunction

  task automatic chk(input string tag, input string what, input logic [31:0] act,
                     input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s.%s got=%0h want=%0h", tag, what, act, expv);
    end
  endtask

  // Drive one cycle shortly after the rising edge, compare just before the next one.
  task automatic run_vec(input vec_t v);
    vec_t e;
    reset           = v.rst;
    pipe_wb_valid   = v.pv;
    pipe_wb_rd      = v.prd;
    pipe_wb_data    = v.pdata;
    md_start        = v.ms;
    md_start_rd     = v.mrd;
    md_start_is_div = v.mdiv;
    md_resultRDY    = v.rdy;
    md_result       = v.res;
    md_exception    = v.exc;
    src_a_rd        = v.sa;
    src_b_rd        = v.sb;
    exp_q.push_back(v);
    #3;
    e = exp_q.pop_front();
    chk(e.tag, "rf_we", 32'(rf_we), 32'(e.e_we));
    chk(e.tag, "rf_rd", 32'(rf_rd), 32'(e.e_rd));
    chk(e.tag, "rf_data", rf_data, e.e_data);
    chk(e.tag, "md_issue_stall", 32'(md_issue_stall), 32'(e.e_stall));
    chk(e.tag, "raw_hazard", 32'(raw_hazard), 32'(e.e_haz));
    chk(e.tag, "pipe_hold", 32'(pipe_hold), 32'(e.e_hold));
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; pipe_wb_valid = 1'b0; pipe_wb_rd = '0; pipe_wb_data = '0;
    md_start = 1'b0; md_start_rd = '0; md_start_is_div = 1'b0; md_resultRDY = 1'b0;
    md_result = '0; md_exception = 1'b0; src_a_rd = '0; src_b_rd = '0;
    repeat (2) @(posedge clock);
    #1;

    //             tag             rst pv prd pdata          ms mrd dv rdy res           ex sa sb  we rd data          st hz hd
    tbl.push_back(mk("rst",          1, 0, 0,  0,             0, 0, 0, 0, 0,            0, 0, 0,  0, 0, 0,            0, 0, 0));
    tbl.push_back(mk("pipe_idle",    0, 1, 17, 32'h0000_CAFE, 0, 0, 0, 0, 0,            0, 0, 0,  1, 17, 32'h0000_CAFE, 0, 0, 0));
    tbl.push_back(mk("t1_issue",     0, 0, 0,  0,             1, 7, 0, 0, 0,            0, 7, 0,  0, 0, 0,            0, 0, 0));
    tbl.push_back(mk("t1_haz_rd",    0, 0, 0,  0,             0, 0, 0, 0, 0,            0, 7, 0,  0, 0, 0,            1, 1, 0));
    tbl.push_back(mk("t1_haz_st",    0, 0, 0,  0,             0, 0, 0, 0, 0,            0, 0, 30, 0, 0, 0,            1, 1, 0));
    tbl.push_back(mk("t1_no_haz",    0, 0, 0,  0,             0, 0, 0, 0, 0,            0, 3, 0,  0, 0, 0,            1, 0, 0));
    tbl.push_back(mk("t1_done",      0, 0, 0,  0,             0, 0, 0, 1, 32'h42,       0, 0, 0,  1, 7, 32'h42,       1, 0, 0));
    tbl.push_back(mk("t1_idle",      0, 0, 0,  0,             0, 0, 0, 0, 0,            0, 7, 0,  0, 0, 0,            0, 0, 0));
    tbl.push_back(mk("t5_issue9",    0, 0, 0,  0,             1, 9, 0, 0, 0,            0, 0, 0,  0, 0, 0,            0, 0, 0));
    tbl.push_back(mk("t5_reissue",   0, 0, 0,  0,             1, 5, 1, 0, 0,            0, 5, 0,  0, 0, 0,            1, 0, 0));
    tbl.push_back(mk("t2_collide",   0, 1, 3,  32'hAAAA_0000, 0, 0, 0, 1, 32'h1234_5678, 0, 9, 0,  1, 3, 32'hAAAA_0000, 1, 1, 0));
    tbl.push_back(mk("t2_drain",     0, 0, 0,  0,             0, 0, 0, 0, 0,            0, 9, 0,  1, 9, 32'h1234_5678, 1, 1, 0));
    tbl.push_back(mk("t2_after",     0, 0, 0,  0,             0, 0, 0, 0, 0,            0, 9, 0,  0, 0, 0,            0, 0, 0));
    tbl.push_back(mk("t5_r0_write",  0, 1, 0,  32'hFFFF_FFFF, 0, 0, 0, 0, 0,            0, 0, 0,  0, 0, 0,            0, 0, 0));
    tbl.push_back(mk("t4_div",       0, 0, 0,  0,             1, 12, 1, 0, 0,           0, 0, 0,  0, 0, 0,            0, 0, 0));
    tbl.push_back(mk("t4_haz_b",     0, 0, 0,  0,             0, 0, 0, 0, 0,            0, 0, 12, 0, 0, 0,            1, 1, 0));
    tbl.push_back(mk("t4_div_exc",   0, 0, 0,  0,             0, 0, 0, 1, 32'hDEAD,     1, 0, 0,  1, 30, 5,           1, 0, 0));
    tbl.push_back(mk("t4_mul",       0, 0, 0,  0,             1, 12, 0, 0, 0,           0, 0, 0,  0, 0, 0,            0, 0, 0));
    tbl.push_back(mk("t4_mul_exc",   0, 0, 0,  0,             0, 0, 0, 1, 32'hBEEF,     1, 0, 0,  1, 30, 4,           1, 0, 0));
    tbl.push_back(mk("t4_div2",      0, 0, 0,  0,             1, 6, 1, 0, 0,            0, 0, 0,  0, 0, 0,            0, 0, 0));
    tbl.push_back(mk("t4_exc_coll",  0, 1, 2,  32'h11,        0, 0, 0, 1, 0,            1, 0, 0,  1, 2, 32'h11,       1, 0, 0));
    tbl.push_back(mk("t4_exc_drain", 0, 0, 0,  0,             0, 0, 0, 0, 0,            0, 30, 0, 1, 30, 5,           1, 1, 0));
    tbl.push_back(mk("t5_rd0_issue", 0, 0, 0,  0,             1, 0, 0, 0, 0,            0, 0, 0,  0, 0, 0,            0, 0, 0));
    tbl.push_back(mk("t5_rd0_done",  0, 0, 0,  0,             0, 0, 0, 1, 32'h99,       0, 0, 0,  0, 0, 0,            1, 0, 0));
    tbl.push_back(mk("t5_rd0_idle",  0, 0, 0,  0,             1, 4, 0, 0, 0,            0, 0, 0,  0, 0, 0,            0, 0, 0));
    tbl.push_back(mk("t5_rd4_busy",  0, 0, 0,  0,             0, 0, 0, 0, 0,            0, 4, 0,  0, 0, 0,            1, 1, 0));
    tbl.push_back(mk("t5_rd4_done",  0, 0, 0,  0,             0, 0, 0, 1, 32'h77,       0, 0, 0,  1, 4, 32'h77,       1, 0, 0));
    tbl.push_back(mk("t5_rdy_idle",  0, 0, 0,  0,             0, 0, 0, 1, 32'h55,       0, 0, 0,  0, 0, 0,            0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

    // Starvation: pipeline writes every cycle while the buffered result waits.
    run_vec(mk("st_issue",    0, 0, 0, 0,          1, 9, 0, 0, 0,          0, 0, 0, 0, 0, 0,          0, 0, 0));
    run_vec(mk("st_collide",  0, 1, 1, 32'h100,    0, 0, 0, 1, 32'hBEEF,   0, 0, 0, 1, 1, 32'h100,    1, 0, 0));
    for (int k = 0; k < 4; k++) begin
      run_vec(mk("st_starve", 0, 1, 2 + k, 32'h200 + k, 0, 0, 0, 0, 0, 0, 0, 0,
                 1, 2 + k, 32'h200 + k, 1, 0, 0));
    end
    run_vec(mk("st_hold",     0, 1, 20, 32'h300,   1, 11, 0, 0, 0,         0, 0, 0, 1, 9, 32'hBEEF,   1, 0, 1));
    run_vec(mk("st_release",  0, 1, 21, 32'h400,   0, 0, 0, 0, 0,          0, 0, 0, 1, 21, 32'h400,   0, 0, 0));

    // Reset while a buffered result is pending discards it.
    run_vec(mk("rs_issue",    0, 0, 0, 0,          1, 9, 0, 0, 0,          0, 0, 0, 0, 0, 0,          0, 0, 0));
    run_vec(mk("rs_collide",  0, 1, 3, 32'h33,     0, 0, 0, 1, 32'h5A,     0, 0, 0, 1, 3, 32'h33,     1, 0, 0));
    run_vec(mk("rs_reset",    1, 1, 8, 32'h88,     0, 0, 0, 0, 0,          0, 9, 0, 1, 8, 32'h88,     1, 1, 0));
    run_vec(mk("rs_after",    0, 0, 0, 0,          0, 0, 0, 0, 0,          0, 9, 0, 0, 0, 0,          0, 0, 0));
    run_vec(mk("rs_stray_rdy",0, 0, 0, 0,          0, 0, 0, 1, 32'h66,     0, 0, 0, 0, 0, 0,          0, 0, 0));

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
